// File: rtl/load_use_forward_if.sv
// Decode-side bundle for the BEAN-2 forwarding/interlock unit: D-stage operand
// usage and destination in, E-stage mux selects and pipeline controls out.
interface load_use_forward_if #(
    parameter int CNT_W = 16
);
    logic [1:0]       reg_RD;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rs3;
    logic             reg_WE;
    logic             mem_RD;
    logic             hold;
    logic [1:0]       fwd_A_sel;
    logic [1:0]       fwd_B_sel;
    logic             stall_F;
    logic             stall_D;
    logic             flush_E;
    logic [CNT_W-1:0] lu_count;

    // Decode stage drives the instruction description and consumes the controls.
    modport master (
        output reg_RD, rs1, rs2, rs3, reg_WE, mem_RD, hold,
        input  fwd_A_sel, fwd_B_sel, stall_F, stall_D, flush_E, lu_count
    );

    // The forwarding unit itself.
    modport slave (
        input  reg_RD, rs1, rs2, rs3, reg_WE, mem_RD, hold,
        output fwd_A_sel, fwd_B_sel, stall_F, stall_D, flush_E, lu_count
    );
endinterface

// File: rtl/load_use_forward.sv
// Operand forwarding and load-use interlock for the BEAN-2 five-stage pipeline:
// tracks destinations through E and M, steers E-stage operand muxes, bubbles on load-use.
module load_use_forward #(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    load_use_forward_if.slave   bus
);
    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_M  = 2'b01;
    localparam logic [1:0] SEL_WB = 2'b10;

    logic [4:0]       rd_e_r;
    logic             we_e_r;
    logic             ld_e_r;
    logic [4:0]       rd_m_r;
    logic             we_m_r;
    logic [1:0]       fwd_a_r;
    logic [1:0]       fwd_b_r;
    logic [CNT_W-1:0] lu_count_r;

    logic             eff_e_s;
    logic             eff_m_s;
    logic             lu_s;
    logic [1:0]       next_a_s;
    logic [1:0]       next_b_s;
    logic             stall_s;
    logic             flush_s;

    // A source only forwards from the youngest effective producer; WB writes are
    // already visible through the write-before-read register file.
    function automatic logic [1:0] pick_src(
        input logic       used,
        input logic [4:0] rs,
        input logic       eff_e,
        input logic [4:0] rd_e,
        input logic       eff_m,
        input logic [4:0] rd_m
    );
        logic [1:0] sel;
        if (!used) begin
            sel = SEL_RF;
        end else if (eff_e && (rd_e == rs)) begin
            sel = SEL_M;
        end else if (eff_m && (rd_m == rs)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Dependency detection and next forward selects from D inputs and E/M state.
    always_comb begin
        eff_e_s  = we_e_r && (rd_e_r != 5'd0);
        eff_m_s  = we_m_r && (rd_m_r != 5'd0);
        lu_s     = ld_e_r && eff_e_s &&
                   ((bus.reg_RD[0] && (rd_e_r == bus.rs1)) ||
                    (bus.reg_RD[1] && (rd_e_r == bus.rs2)));
        next_a_s = pick_src(bus.reg_RD[0], bus.rs1, eff_e_s, rd_e_r, eff_m_s, rd_m_r);
        next_b_s = pick_src(bus.reg_RD[1], bus.rs2, eff_e_s, rd_e_r, eff_m_s, rd_m_r);
    end

    // Pipeline controls: reset masks everything, hold freezes without a bubble.
    always_comb begin
        stall_s = 1'b0;
        flush_s = 1'b0;
        if (reset) begin
            stall_s = 1'b0;
            flush_s = 1'b0;
        end else if (bus.hold) begin
            stall_s = 1'b1;
            flush_s = 1'b0;
        end else if (lu_s) begin
            stall_s = 1'b1;
            flush_s = 1'b1;
        end else begin
            stall_s = 1'b0;
            flush_s = 1'b0;
        end
    end

    // E/M destination tracking, registered selects and the saturating bubble count.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_e_r     <= 5'd0;
            we_e_r     <= 1'b0;
            ld_e_r     <= 1'b0;
            rd_m_r     <= 5'd0;
            we_m_r     <= 1'b0;
            fwd_a_r    <= SEL_RF;
            fwd_b_r    <= SEL_RF;
            lu_count_r <= {CNT_W{1'b0}};
        end else if (bus.hold) begin
            rd_e_r     <= rd_e_r;
            we_e_r     <= we_e_r;
            ld_e_r     <= ld_e_r;
            rd_m_r     <= rd_m_r;
            we_m_r     <= we_m_r;
            fwd_a_r    <= fwd_a_r;
            fwd_b_r    <= fwd_b_r;
            lu_count_r <= lu_count_r;
        end else if (lu_s) begin
            rd_e_r  <= 5'd0;
            we_e_r  <= 1'b0;
            ld_e_r  <= 1'b0;
            rd_m_r  <= rd_e_r;
            we_m_r  <= we_e_r;
            fwd_a_r <= SEL_RF;
            fwd_b_r <= SEL_RF;
            if (lu_count_r != {CNT_W{1'b1}}) begin
                lu_count_r <= lu_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                lu_count_r <= lu_count_r;
            end
        end else begin
            rd_e_r     <= bus.rs3;
            we_e_r     <= bus.reg_WE;
            ld_e_r     <= bus.mem_RD;
            rd_m_r     <= rd_e_r;
            we_m_r     <= we_e_r;
            fwd_a_r    <= next_a_s;
            fwd_b_r    <= next_b_s;
            lu_count_r <= lu_count_r;
        end
    end

    assign bus.fwd_A_sel = fwd_a_r;
    assign bus.fwd_B_sel = fwd_b_r;
    assign bus.stall_F   = stall_s;
    assign bus.stall_D   = stall_s;
    assign bus.flush_E   = flush_s;
    assign bus.lu_count  = lu_count_r;
endmodule

// File: tb/tb_load_use_forward.sv
// Directed scoreboard bench for load_use_forward; a second CNT_W=2 instance
// sees the same stimulus to exercise counter saturation.
module tb_load_use_forward;
    logic clk;
    logic reset;

    load_use_forward_if #(.CNT_W(16)) bif ();
    load_use_forward_if #(.CNT_W(2))  sif ();

    load_use_forward #(.CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bif.slave));
    load_use_forward #(.CNT_W(2))  dut_sat (.clk(clk), .reset(reset), .bus(sif.slave));

    assign sif.reg_RD = bif.reg_RD;
    assign sif.rs1    = bif.rs1;
    assign sif.rs2    = bif.rs2;
    assign sif.rs3    = bif.rs3;
    assign sif.reg_WE = bif.reg_WE;
    assign sif.mem_RD = bif.mem_RD;
    assign sif.hold   = bif.hold;

    typedef struct {
        int   id;
        logic sf;
        logic fe;
        int   ea;
        int   eb;
        int   cnt;
        int   scnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   step_id = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall_F", e.id, {31'd0, bif.stall_F}, {31'd0, e.sf});
            chk("stall_D", e.id, {31'd0, bif.stall_D}, {31'd0, e.sf});
            chk("flush_E", e.id, {31'd0, bif.flush_E}, {31'd0, e.fe});
            if (e.ea >= 0) chk("fwd_A_sel", e.id, {30'd0, bif.fwd_A_sel}, e.ea);
            if (e.eb >= 0) chk("fwd_B_sel", e.id, {30'd0, bif.fwd_B_sel}, e.eb);
            if (e.cnt >= 0) chk("lu_count", e.id, {16'd0, bif.lu_count}, e.cnt);
            if (e.scnt >= 0) chk("lu_count_sat", e.id, {30'd0, sif.lu_count}, e.scnt);
        end
    end

    // One D-stage cycle: drive inputs and queue what that cycle must show (-1 = unchecked).
    task automatic step(input logic [1:0] rrd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] r3, input logic we, input logic ld,
                        input logic hd, input logic rs, input logic sf, input logic fe,
                        input int ea, input int eb, input int cnt, input int scnt);
        exp_t x;
        @(posedge clk);
        #1;
        bif.reg_RD = rrd; bif.rs1 = r1; bif.rs2 = r2; bif.rs3 = r3;
        bif.reg_WE = we; bif.mem_RD = ld; bif.hold = hd; reset = rs;
        step_id++;
        x.id = step_id; x.sf = sf; x.fe = fe;
        x.ea = ea; x.eb = eb; x.cnt = cnt; x.scnt = scnt;
        sb.push_back(x);
    endtask

    task automatic nop(input int ea, input int eb, input int cnt, input int scnt);
        step(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, cnt, scnt);
    endtask

    initial begin
        reset = 1'b1;
        bif.reg_RD = 2'b00; bif.rs1 = 5'd0; bif.rs2 = 5'd0; bif.rs3 = 5'd0;
        bif.reg_WE = 1'b0; bif.mem_RD = 1'b0; bif.hold = 1'b0;

        // Reset state
        step(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        nop(0, 0, 0, 0);

        // ALU back-to-back
        step(2'b00, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, -1);
        step(2'b01, 5'd5, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        nop(1, 0, 0, -1);

        // Distance one beats distance two
        step(2'b00, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        step(2'b00, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        step(2'b10, 5'd0, 5'd6, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        nop(0, 1, -1, -1);

        // Distance two forwards from WB
        step(2'b00, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        step(2'b00, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        step(2'b10, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        nop(0, 2, -1, -1);

        // Load-use: one bubble, then WB forward on operand B
        step(2'b01, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, -1);
        step(2'b11, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, -1);
        step(2'b11, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, -1);
        nop(0, 2, 1, -1);

        // x0 is never a dependency
        step(2'b00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        step(2'b11, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        nop(0, 0, 1, -1);

        // Unused source does not interlock
        step(2'b00, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1);
        step(2'b10, 5'd9, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1);
        nop(0, 0, 1, -1);

        // Hold during a pending load-use freezes selects and count
        step(2'b00, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, -1, -1);
        step(2'b01, 5'd14, 5'd0, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, -1);
        for (int i = 0; i < 3; i++)
            step(2'b01, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 0, 1, -1);
        step(2'b01, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 0, 1, -1);
        step(2'b01, 5'd13, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2, -1);
        nop(2, 0, 2, -1);

        // Reset in the load-use cycle
        step(2'b00, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2, -1);
        step(2'b01, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 2, -1);
        step(2'b01, 5'd15, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
        nop(0, 0, 0, 0);

        // Five load-use pairs; the 2-bit counter stops at 3
        for (int k = 1; k <= 5; k++) begin
            step(2'b00, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, -1, -1);
            step(2'b01, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1,
                 k - 1, (k - 1 > 3) ? 3 : k - 1);
            step(2'b01, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0,
                 k, (k > 3) ? 3 : k);
        end
        nop(2, 0, 5, 3);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
